gray_count_receiver: RTL

//  Receive end of a Gray-coded count crossing into the clk domain (e.g. a FIFO pointer or event counter).

---
 rtl/gray_pkg.sv | 32 +++
 rtl/gray_count_receiver_if.sv | 42 ++++
 rtl/gray2bin.sv | 18 +
 rtl/gray_count_receiver.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-coded count receiver.
// Helpers work on a fixed wide vector; callers zero-extend narrower counts,
// which leaves the low bits of every result unchanged.
package gray_pkg;

    localparam int unsigned MAX_W = 32;

    typedef logic [MAX_W-1:0] wide_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PRIME = 2'd1,
        TRACK = 2'd2
    } grx_state_t;

    // Prefix-XOR from the MSB down: bin[i] = ^gray[MAX_W-1:i]
    function automatic wide_t gray2bin_f(input wide_t g);
        wide_t b;
        b = '0;
        b[MAX_W-1] = g[MAX_W-1];
        for (int unsigned k = 1; k < MAX_W; k++) begin
            b[MAX_W-1-k] = b[MAX_W-k] ^ g[MAX_W-1-k];
        end
        return b;
    endfunction

    // True when exactly one bit differs between the two codes
    function automatic logic is_single_bit_change(input wide_t a, input wide_t b);
        return $onehot(a ^ b);
    endfunction

endpackage

// File: rtl/gray_count_receiver_if.sv
// Bus bundle between the Gray-count receiver and its surroundings.
// master: the side that supplies gray_in and consumes the step handshake.
// slave:  the receiver itself.
interface gray_count_receiver_if #(
    parameter int N = 8
);

    logic [N-1:0] gray_in;
    logic [N-1:0] bin_out;
    logic         primed;
    logic         step_valid;
    logic         step_ready;
    logic [N-1:0] delta_count;
    logic         err_skip;
    logic         err_ovf;
    logic         err_clr;

    modport master (
        output gray_in,
        output step_ready,
        output err_clr,
        input  bin_out,
        input  primed,
        input  step_valid,
        input  delta_count,
        input  err_skip,
        input  err_ovf
    );

    modport slave (
        input  gray_in,
        input  step_ready,
        input  err_clr,
        output bin_out,
        output primed,
        output step_valid,
        output delta_count,
        output err_skip,
        output err_ovf
    );

endinterface

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder of parameterised width.
module gray2bin #(
    parameter int N = 8
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    // Ripple the XOR from the MSB toward the LSB
    always_comb begin
        bin = '0;
        bin[N-1] = gray[N-1];
        for (int unsigned k = 1; k < N; k++) begin
            bin[N-1-k] = bin[N-k] ^ gray[N-1-k];
        end
    end

endmodule

// File: rtl/gray_count_receiver.sv
// Receive end of a Gray-coded count crossing into the clk domain.
// Synchronises gray_in, decodes it, validates each transition as a single
// forward Gray step, and accumulates forward steps for a valid/ready consumer.
// Skips/backward steps and accumulator saturation raise sticky error flags.
// Width N must not exceed gray_pkg::MAX_W.
module gray_count_receiver
    import gray_pkg::*;
#(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic                  clk,
    input logic                  rstn,
    gray_count_receiver_if.slave bus
);

    localparam int              CW        = $clog2(SYNC_STAGES);
    localparam logic [CW-1:0]   FILL_LAST = CW'(SYNC_STAGES - 1);
    localparam logic [N-1:0]    ACC_MAX   = '1;

    grx_state_t    state_q;
    logic [CW-1:0] fill_cnt_q;

    logic [N-1:0]  g_s;
    logic [N-1:0]  g_prev_q;
    logic [N-1:0]  bin_s;
    logic [N-1:0]  bin_q;
    logic          primed_q;

    logic [N-1:0]  acc_q;
    logic [N-1:0]  acc_n;
    logic          valid_q;
    logic          err_skip_q;
    logic          err_ovf_q;

    logic          tracking;
    logic          changed;
    logic          single;
    logic          forward;
    logic          inc;
    logic          skip_new;
    logic          fire;
    logic          ovf_new;

    // Input synchroniser: one register per stage, stage 0 samples gray_in
    for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
        logic [N-1:0] q;
        if (s == 0) begin : g_first
            // First stage captures the asynchronous Gray count
            always_ff @(posedge clk) begin
                if (!rstn) q <= '0;
                else       q <= bus.gray_in;
            end
        end else begin : g_next
            // Later stages shift the sample along the chain
            always_ff @(posedge clk) begin
                if (!rstn) q <= '0;
                else       q <= g_sync[s-1].q;
            end
        end
    end

    assign g_s = g_sync[SYNC_STAGES-1].q;

    gray2bin #(.N(N)) u_dec (
        .gray (g_s),
        .bin  (bin_s)
    );

    // Classify the synchronised sample against the previous one.
    // bin_q always holds the decode of g_prev_q, so it serves as the
    // previous binary value without a second decoder.
    always_comb begin
        tracking = (state_q == TRACK);
        changed  = (g_s != g_prev_q);
        single   = is_single_bit_change(wide_t'(g_s), wide_t'(g_prev_q));
        forward  = ((bin_s - bin_q) == N'(1));
        inc      = tracking && single && forward;
        skip_new = tracking && changed && !(single && forward);
    end

    // Next accumulator value: a handshake restarts from the current step,
    // otherwise count up and saturate at the maximum
    always_comb begin
        fire    = valid_q && bus.step_ready;
        acc_n   = acc_q;
        ovf_new = 1'b0;
        if (fire) begin
            acc_n = {{(N-1){1'b0}}, inc};
        end else if (inc) begin
            if (acc_q == ACC_MAX) ovf_new = 1'b1;
            else                  acc_n   = acc_q + N'(1);
        end
    end

    // Sequencer: wait for the chain to fill, take a baseline, then track
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
            g_prev_q   <= '0;
            bin_q      <= '0;
            primed_q   <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (fill_cnt_q == FILL_LAST) state_q <= PRIME;
                    else                         fill_cnt_q <= fill_cnt_q + CW'(1);
                end
                PRIME: begin
                    g_prev_q <= g_s;
                    bin_q    <= bin_s;
                    primed_q <= 1'b1;
                    state_q  <= TRACK;
                end
                TRACK: begin
                    g_prev_q <= g_s;
                    bin_q    <= bin_s;
                end
                default: state_q <= FILL;
            endcase
        end
    end

    // Step accumulator and its registered valid flag
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_n;
            valid_q <= (acc_n != '0);
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps its flag set
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_skip_q <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            err_skip_q <= (err_skip_q && !bus.err_clr) || skip_new;
            err_ovf_q  <= (err_ovf_q  && !bus.err_clr) || ovf_new;
        end
    end

    assign bus.bin_out     = bin_q;
    assign bus.primed      = primed_q;
    assign bus.step_valid  = valid_q;
    assign bus.delta_count = acc_q;
    assign bus.err_skip    = err_skip_q;
    assign bus.err_ovf     = err_ovf_q;

endmodule
